// File: rtl/music_pkg.sv
// Shared definitions for the music player.
//   state_t             : sequencer states
//   REST_PERIOD         : note value that means silence
//   DEFAULT_BEAT_CYCLES : clock cycles per ROM entry (sixteenth note at 50 MHz)
package music_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PLAY,
    PAUSE,
    DONE
  } state_t;

  localparam int unsigned REST_PERIOD         = 2500;
  localparam int unsigned DEFAULT_BEAT_CYCLES = 12_500_000;

endpackage

// File: rtl/music_player_tone_gen.sv
// Square-wave tone generator.
//   clk, rst : clock, synchronous active-high reset
//   period   : tone period in clock cycles (REST_PERIOD, 0 or 1 mean silence)
//   enable   : advance the tone counter and update the square register
//   restart  : treat the counter as 0 this cycle; when not enabled, clears
//              both the counter and the square register
//   square   : registered square wave, high while the count < period/2
module tone_gen #(
  parameter int unsigned NOTE_W      = 32,
  parameter int unsigned REST_PERIOD = music_pkg::REST_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] period,
  input  logic              enable,
  input  logic              restart,
  output logic              square
);

  logic [NOTE_W-1:0] tone_cnt;
  logic [NOTE_W-1:0] eff_cnt;
  logic              is_rest;

  always_comb begin
    eff_cnt = restart ? '0 : tone_cnt;
    is_rest = (period == NOTE_W'(REST_PERIOD)) || (period <= NOTE_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tone_cnt <= '0;
      square   <= 1'b0;
    end else if (enable) begin
      if (is_rest) begin
        tone_cnt <= '0;
        square   <= 1'b0;
      end else begin
        square   <= (eff_cnt < (period >> 1));
        tone_cnt <= (eff_cnt >= period - NOTE_W'(1)) ? '0 : eff_cnt + NOTE_W'(1);
      end
    end else if (restart) begin
      tone_cnt <= '0;
      square   <= 1'b0;
    end
  end

endmodule

// File: rtl/music_player.sv
// Song sequencer: walks the song ROM one entry per beat and drives a buzzer.
//   clk, rst  : clock, synchronous active-high reset
//   start     : pulse, play from address 0 (only from IDLE)
//   stop      : pulse, abort playback (wins over start)
//   pause     : level, freeze playback while high
//   loop_en   : level, wrap to address 0 after LAST_ADDR
//   rom_addr  : registered song ROM address
//   rom_note  : ROM data (note period), valid one clock after rom_addr
//   buzzer    : square-wave tone output
//   playing   : high in FETCH, PLAY and PAUSE
//   done      : one-cycle pulse when the song ends without looping
module music_player #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned LAST_ADDR   = 127,
  parameter int unsigned NOTE_W      = 32,
  parameter int unsigned BEAT_CYCLES = music_pkg::DEFAULT_BEAT_CYCLES,
  parameter int unsigned REST_PERIOD = music_pkg::REST_PERIOD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_note,
  output logic              buzzer,
  output logic              playing,
  output logic              done
);

  import music_pkg::*;

  localparam int unsigned       BEAT_W        = $clog2(BEAT_CYCLES);
  localparam logic [BEAT_W-1:0] BEAT_LAST     = BEAT_W'(BEAT_CYCLES - 1);
  localparam logic [BEAT_W-1:0] BEAT_PREFETCH = BEAT_W'(BEAT_CYCLES - 2);
  localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(LAST_ADDR);

  state_t            state, state_next;
  logic [BEAT_W-1:0] beat_cnt;
  logic [NOTE_W-1:0] prev_note;
  logic [NOTE_W-1:0] period;
  logic              last_beat;
  logic              advance;
  logic              beat_start;
  logic              restart;
  logic              square;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; stop beats song end, song end beats pause
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start && !stop) state_next = FETCH;
      FETCH: state_next = stop ? IDLE : PLAY;
      PLAY: begin
        if (stop)                                   state_next = IDLE;
        else if (beat_cnt == BEAT_LAST && last_beat) state_next = DONE;
        else if (pause)                              state_next = PAUSE;
      end
      PAUSE: begin
        if (stop)        state_next = IDLE;
        else if (!pause) state_next = PLAY;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; the tone register holds through PAUSE so the waveform resumes
  // exactly where it froze, and is masked outside PLAY.
  always_comb begin
    playing = (state == FETCH) || (state == PLAY) || (state == PAUSE);
    done    = (state == DONE);
    buzzer  = square && (state == PLAY);
  end

  // prev_note doubles as the current note after the first cycle of a beat,
  // so a pause spanning the prefetch never picks up the next entry early.
  always_comb begin
    advance    = (state == PLAY) && !stop;
    beat_start = (state == PLAY) && (beat_cnt == '0);
    period     = beat_start ? rom_note : prev_note;
    restart    = (state == FETCH) || (beat_start && (rom_note != prev_note));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= '0;
      beat_cnt  <= '0;
      prev_note <= '0;
      last_beat <= 1'b0;
    end else begin
      if (state == IDLE && start && !stop) rom_addr <= '0;
      if (state == FETCH) begin
        beat_cnt  <= '0;
        last_beat <= 1'b0;
      end
      if (advance) begin
        beat_cnt <= (beat_cnt == BEAT_LAST) ? '0 : beat_cnt + BEAT_W'(1);
        if (beat_start) prev_note <= rom_note;
        if (beat_cnt == BEAT_PREFETCH) begin
          if (rom_addr == ADDR_LAST) begin
            last_beat <= !loop_en;
            if (loop_en) rom_addr <= '0;
          end else begin
            rom_addr  <= rom_addr + ADDR_W'(1);
            last_beat <= 1'b0;
          end
        end
      end
    end
  end

  tone_gen #(
    .NOTE_W      (NOTE_W),
    .REST_PERIOD (REST_PERIOD)
  ) u_tone_gen (
    .clk     (clk),
    .rst     (rst),
    .period  (period),
    .enable  (advance),
    .restart (restart),
    .square  (square)
  );

endmodule

// File: tb/tb_music_player.sv
module tb_music_player;

  localparam int B      = 8;
  localparam int L      = 3;
  localparam int SONG   = B * (L + 1);
  localparam int MAXP   = 1024;
  localparam int REST   = 2500;
  localparam int M_IDLE = 0, M_FETCH = 1, M_PLAY = 2, M_PAUSE = 3, M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [1:0]  rom_addr;
  logic [31:0] rom_note;
  logic        buzzer, playing, done;

  logic [31:0] rom [0:3];

  int vecs = 0;
  int errs = 0;

  // Reference model: song progress measured in PLAY cycles
  int   m_mode = M_IDLE;
  int   m_pc   = 0;
  int   m_addr = 0;
  bit   m_loop = 1'b0;
  bit   hi [0:MAXP-1];
  logic [1:0] e_addr;
  logic e_buz, e_play, e_done;

  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_note <= rom[rom_addr];

  music_player #(
    .ADDR_W      (2),
    .LAST_ADDR   (3),
    .NOTE_W      (32),
    .BEAT_CYCLES (8),
    .REST_PERIOD (2500)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
    .rom_addr (rom_addr),
    .rom_note (rom_note),
    .buzzer   (buzzer),
    .playing  (playing),
    .done     (done)
  );

  // Expected tone level for each PLAY cycle q of a song (looping over entries)
  task automatic build_hi();
    int tone = 0;
    int n, pn = -1;
    bit rest;
    for (int q = 0; q < MAXP; q++) begin
      n = int'(rom[(q / B) % (L + 1)]);
      if (q % B == 0 && (q == 0 || n != pn)) tone = 0;
      rest  = (n == REST) || (n <= 1);
      hi[q] = rest ? 1'b0 : (tone < n / 2);
      tone  = rest ? 0 : (tone + 1) % n;
      pn    = n;
    end
  endtask

  // Address presented while the song has completed pc PLAY cycles
  function automatic int addr_of(input int pc);
    int a = (pc + 1) / B;
    if (m_loop) return a % (L + 1);
    return (a > L) ? L : a;
  endfunction

  task automatic load_rom(input int a, input int b, input int c, input int d);
    rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
    build_hi();
  endtask

  task automatic tick(input bit s, input bit t, input bit p, input bit r);
    start = s; stop = t; pause = p; rst = r;
    @(posedge clk);
    if (r) begin
      m_mode = M_IDLE; m_pc = 0; m_addr = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (s && !t) begin m_mode = M_FETCH; m_addr = 0; m_loop = loop_en; end
        M_FETCH: if (t) m_mode = M_IDLE; else begin m_mode = M_PLAY; m_pc = 0; end
        M_PLAY: begin
          if (t) m_mode = M_IDLE;
          else begin
            m_pc++;
            m_addr = addr_of(m_pc);
            if (!m_loop && m_pc == SONG) m_mode = M_DONE;
            else if (p)                  m_mode = M_PAUSE;
          end
        end
        M_PAUSE: if (t) m_mode = M_IDLE; else if (!p) m_mode = M_PLAY;
        default: m_mode = M_IDLE;
      endcase
    end
    #1;
    start = 1'b0; stop = 1'b0; rst = 1'b0;
    e_addr = 2'(m_addr);
    e_play = (m_mode == M_FETCH) || (m_mode == M_PLAY) || (m_mode == M_PAUSE);
    e_done = (m_mode == M_DONE);
    e_buz  = (m_mode == M_PLAY && m_pc > 0) ? hi[m_pc - 1] : 1'b0;
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
    if ({rom_addr, buzzer, playing, done} !== 5'b0) begin
      errs++;
      $display("FAIL reset: addr,buz,play,done got %b,%b,%b,%b want 0,0,0,0", rom_addr, buzzer, playing, done);
    end
    vecs++;
  endtask

  task automatic test_single_play();
    int done_at = -1, done_cnt = 0;
    load_rom(8, 8, 12, REST);
    loop_en = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick(n == 1, 0, 0, 0);
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL single_play n=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 n, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
      if (done === 1'b1) begin done_cnt++; if (done_at < 0) done_at = n; end
    end
    if (done_at != 34 || done_cnt != 1) begin
      errs++;
      $display("FAIL single_play_done: at %0d count %0d want at 34 count 1", done_at, done_cnt);
    end
    vecs++;
  endtask

  task automatic test_loop();
    int done_cnt = 0, idle_cnt = 0;
    load_rom(8, 8, 12, REST);
    loop_en = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      tick(n == 1, 0, 0, 0);
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL loop n=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 n, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
      if (done === 1'b1) done_cnt++;
      if (playing !== 1'b1) idle_cnt++;
    end
    if (done_cnt != 0 || idle_cnt != 0) begin
      errs++;
      $display("FAIL loop_continuous: done pulses %0d not-playing cycles %0d want 0 and 0", done_cnt, idle_cnt);
    end
    vecs++;
    tick(0, 1, 0, 0);
    loop_en = 1'b0;
  endtask

  task automatic test_pause();
    int n = 1, done_at = -1;
    load_rom(8, 8, 12, REST);
    loop_en = 1'b0;
    tick(1, 0, 0, 0);
    while (!(m_mode == M_PLAY && m_pc == 2) && n < 10) begin tick(0, 0, 0, 0); n++; end
    for (int k = 0; k < 80; k++) begin
      tick(0, 0, k < 20, 0);
      n++;
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL pause n=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 n, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
      if (done === 1'b1 && done_at < 0) done_at = n;
    end
    if (done_at != 54) begin
      errs++;
      $display("FAIL pause_length: done at %0d want 54", done_at);
    end
    vecs++;
  endtask

  task automatic test_stop_start();
    int n = 0;
    load_rom(8, 8, 12, REST);
    loop_en = 1'b0;
    tick(1, 0, 0, 0);
    while (!(m_mode == M_PLAY && m_pc == 2 * B + 3) && n < 40) begin tick(0, 0, 0, 0); n++; end
    tick(0, 1, 0, 0);
    if (playing !== 1'b0 || buzzer !== 1'b0) begin
      errs++;
      $display("FAIL stop: play,buz got %b,%b want 0,0", playing, buzzer);
    end
    vecs++;
    for (int k = 0; k < 40; k++) begin
      tick(k == 20, k == 20, 0, 0);
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL stop_idle k=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 k, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
    end
    tick(1, 0, 0, 0);
    n = 0;
    while (m_pc != 10 && n < 20) begin tick(0, 0, 0, 0); n++; end
    tick(1, 0, 0, 0);
    if (rom_addr !== 2'd1 || playing !== 1'b1) begin
      errs++;
      $display("FAIL start_in_play: addr,play got %0d,%b want 1,1", rom_addr, playing);
    end
    vecs++;
    tick(0, 1, 0, 0);
  endtask

  task automatic test_reset_midplay();
    int done_at = -1;
    load_rom(8, 8, 12, REST);
    loop_en = 1'b0;
    tick(1, 0, 0, 0);
    repeat (12) tick(0, 0, 0, 0);
    tick(0, 0, 0, 1);
    if ({rom_addr, buzzer, playing, done} !== 5'b0) begin
      errs++;
      $display("FAIL reset_midplay: addr,buz,play,done got %b,%b,%b,%b want 0,0,0,0", rom_addr, buzzer, playing, done);
    end
    vecs++;
    tick(0, 0, 0, 0);
    for (int n = 1; n <= 40; n++) begin
      tick(n == 1, 0, 0, 0);
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL after_reset n=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 n, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
      if (done === 1'b1 && done_at < 0) done_at = n;
    end
    if (done_at != 34) begin
      errs++;
      $display("FAIL after_reset_done: at %0d want 34", done_at);
    end
    vecs++;
  endtask

  task automatic test_zero_odd();
    int highs = 0;
    load_rom(0, 7, 7, 7);
    loop_en = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick(n == 1, 0, 0, 0);
      if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
        errs++;
        $display("FAIL zero_odd n=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                 n, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
      end
      vecs++;
      if (buzzer === 1'b1) highs++;
    end
    // 23 visible cycles of a sustained 7-cycle tone (3 high each period)
    if (highs != 11) begin
      errs++;
      $display("FAIL zero_odd_highs: got %0d high cycles want 11", highs);
    end
    vecs++;
  endtask

  task automatic test_random();
    int  vals [10] = '{0, 1, 2, 3, 5, 6, 7, 8, 11, REST};
    bit  pz;
    int  r;
    for (int s = 0; s < 10; s++) begin
      for (int a = 0; a < 4; a++)
        rom[a] = (a > 0 && $urandom_range(0, 2) == 0) ? rom[a - 1] : 32'(vals[$urandom_range(0, 9)]);
      build_hi();
      loop_en = 1'($urandom_range(0, 1));
      pz = 1'b0;
      tick(1, 0, 0, 0);
      for (int k = 0; k < 180; k++) begin
        r = $urandom_range(0, 199);
        if ($urandom_range(0, 15) == 0) pz = !pz;
        tick(r < 6, r == 199 || r == 100, pz, r == 198);
        if ({rom_addr, buzzer, playing, done} !== {e_addr, e_buz, e_play, e_done}) begin
          errs++;
          $display("FAIL random s=%0d k=%0d: addr,buz,play,done got %b,%b,%b,%b want %b,%b,%b,%b",
                   s, k, rom_addr, buzzer, playing, done, e_addr, e_buz, e_play, e_done);
        end
        vecs++;
      end
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
  endtask

  initial begin
    rom[0] = 0; rom[1] = 0; rom[2] = 0; rom[3] = 0;
    test_reset();
    test_single_play();
    test_loop();
    test_pause();
    test_stop_start();
    test_reset_midplay();
    test_zero_odd();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
